// File: rtl/rxfer_pkg.sv
// rtl/rxfer_pkg.sv - shared types and constants for the register-transfer FSM
//
// Purpose : state encoding, transfer-class opcode/subop constants and
//           select-code helpers used by rxfer_fsm.
// Contents: state_e, OPC_XFER, SUBOP_MOV, SUBOP_SWAP, SEL_NONE, reg_code().
package rxfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_XFER   = 3'd2,
    ST_PCINC  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Default transfer-class opcode and the two legal subops.
  localparam logic [3:0] OPC_XFER   = 4'b0100;
  localparam logic [3:0] SUBOP_MOV  = 4'b0000;
  localparam logic [3:0] SUBOP_SWAP = 4'b0001;

  // Select code 0 means "no register on the bus".
  localparam int SEL_NONE = 0;

  // Register Rk is addressed on the bus by code k+1; the temp register
  // code (NREG+1) depends on NREG and is formed in the FSM itself.
  function automatic int reg_code(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/rxfer_win_ctr.sv
// rtl/rxfer_win_ctr.sv - bus hold window down-counter with last-cycle flag
//
// Purpose: times one transfer step. A load sets the count to BUS_CYC-1; each
//          enabled cycle decrements it; last_o is high while the count is 0,
//          i.e. on the final cycle of the hold window.
// Ports  : clk, rst   - clock, synchronous active-high reset
//          load_i     - start a new window (has priority over en_i)
//          en_i       - count down one cycle (saturates at 0)
//          cnt_o      - current count
//          last_o     - current cycle is the last of the window
module rxfer_win_ctr #(
  parameter int BUS_CYC = 1,
  parameter int CNT_W   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(BUS_CYC - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/rxfer_fsm.sv
// rtl/rxfer_fsm.sv - register-transfer control FSM (MOV / SWAP) for the execute stage
//
// Purpose: decodes a transfer-class instruction and sequences register-bus
//          source/destination select codes, holding each step on the bus for
//          BUS_CYC cycles, then issues one pcInc pulse and one done pulse.
// Ports  : clk, rst      - clock, synchronous active-high reset
//          start         - begin executing instruction (sampled only in IDLE)
//          instruction   - [15:12] opcode, [11:8] subop, [7:4] dst, [3:0] src
//          busy          - instruction in flight (DECODE..DONE)
//          done          - one-cycle retire pulse
//          err           - illegal instruction, held until next accepted start
//          rxOut         - bus source select code
//          rxIn          - bus destination latch-enable code
//          pcInc         - one-cycle PC increment pulse
module rxfer_fsm
  import rxfer_pkg::*;
#(
  parameter int         INSTR_W = 16,
  parameter int         NREG    = 16,
  parameter int         RI_W    = 4,
  parameter int         BUS_CYC = 1,
  parameter logic [3:0] OPC     = OPC_XFER,
  localparam int        SEL_W   = $clog2(NREG + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] instruction,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SEL_W-1:0]   rxOut,
  output logic [SEL_W-1:0]   rxIn,
  output logic               pcInc
);

  localparam int               CNT_W  = (BUS_CYC > 1) ? $clog2(BUS_CYC) : 1;
  localparam logic [SEL_W-1:0] SEL_Z  = SEL_W'(SEL_NONE);
  localparam logic [SEL_W-1:0] T_CODE = SEL_W'(NREG + 1);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [1:0]           step_q,  step_d;
  logic                 err_q,   err_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic                 pcinc_q, pcinc_d;
  logic [SEL_W-1:0]     rxout_q, rxout_d;
  logic [SEL_W-1:0]     rxin_q,  rxin_d;

  logic                 ctr_load;
  logic                 ctr_en;
  logic [CNT_W-1:0]     ctr_cnt;
  logic                 ctr_last;

  // Decode of the latched instruction.
  logic [3:0]           f_opc;
  logic [3:0]           f_sub;
  logic [RI_W-1:0]      f_dst;
  logic [RI_W-1:0]      f_src;
  logic                 dec_ill;
  logic                 dec_swap;
  logic [1:0]           dec_steps;
  logic [SEL_W-1:0]     code_src;
  logic [SEL_W-1:0]     code_dst;

  // Step selection for the next cycle's bus codes.
  logic [1:0]           sidx;
  logic                 drive_bus;
  logic                 strobe_in;
  logic [2*SEL_W-1:0]   sel;

  assign f_opc = instr_q[15:12];
  assign f_sub = instr_q[11:8];
  assign f_dst = instr_q[4 +: RI_W];
  assign f_src = instr_q[0 +: RI_W];

  always_comb begin
    dec_ill  = (f_opc != OPC)
             || ((f_sub != SUBOP_MOV) && (f_sub != SUBOP_SWAP))
             || (int'(f_dst) >= NREG)
             || (int'(f_src) >= NREG);
    dec_swap = (f_sub == SUBOP_SWAP);
    code_src = SEL_W'(reg_code(int'(f_src)));
    code_dst = SEL_W'(reg_code(int'(f_dst)));
    // Self-transfers are architectural no-ops: skip the bus entirely.
    if (dec_ill || (f_src == f_dst)) begin
      dec_steps = 2'd0;
    end else if (dec_swap) begin
      dec_steps = 2'd3;
    end else begin
      dec_steps = 2'd1;
    end
  end

  // Step table, returns {source code, destination code}.
  // SWAP goes through T: T<-Rsrc, Rsrc<-Rdst, Rdst<-T.
  function automatic logic [2*SEL_W-1:0] step_sel(
    input logic             swap,
    input logic [1:0]       idx,
    input logic [SEL_W-1:0] cs,
    input logic [SEL_W-1:0] cd
  );
    logic [2*SEL_W-1:0] r;
    if (!swap) begin
      r = {cs, cd};
    end else begin
      case (idx)
        2'd0:    r = {cs, T_CODE};
        2'd1:    r = {cd, cs};
        default: r = {T_CODE, cd};
      endcase
    end
    return r;
  endfunction

  rxfer_win_ctr #(
    .BUS_CYC (BUS_CYC),
    .CNT_W   (CNT_W)
  ) u_win_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (ctr_load),
    .en_i   (ctr_en),
    .cnt_o  (ctr_cnt),
    .last_o (ctr_last)
  );

  // Next-state and next-output logic. Outputs are registered, so every
  // branch describes what the bus must show in the cycle after this edge.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    step_d    = step_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pcinc_d   = 1'b0;
    rxout_d   = SEL_Z;
    rxin_d    = SEL_Z;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    sidx      = step_q;
    drive_bus = 1'b0;
    strobe_in = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          instr_d = instruction;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          step_d  = 2'd0;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        err_d  = dec_ill;
        step_d = 2'd0;
        if (dec_steps != 2'd0) begin
          state_d   = ST_XFER;
          ctr_load  = 1'b1;
          sidx      = 2'd0;
          drive_bus = 1'b1;
          strobe_in = (BUS_CYC == 1);
        end else begin
          state_d = ST_PCINC;
          pcinc_d = 1'b1;
        end
      end

      ST_XFER: begin
        if (ctr_last) begin
          if (step_q == (dec_steps - 2'd1)) begin
            state_d = ST_PCINC;
            pcinc_d = 1'b1;
          end else begin
            step_d    = step_q + 2'd1;
            sidx      = step_q + 2'd1;
            ctr_load  = 1'b1;
            drive_bus = 1'b1;
            strobe_in = (BUS_CYC == 1);
          end
        end else begin
          // Still inside the window; the destination strobe goes out on the
          // cycle where the count will have reached 0.
          ctr_en    = 1'b1;
          drive_bus = 1'b1;
          strobe_in = (ctr_cnt == CNT_W'(1));
        end
      end

      ST_PCINC: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    sel = step_sel(dec_swap, sidx, code_src, code_dst);
    if (drive_bus) begin
      rxout_d = sel[2*SEL_W-1:SEL_W];
      if (strobe_in) begin
        rxin_d = sel[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      step_q  <= 2'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pcinc_q <= 1'b0;
      rxout_q <= SEL_Z;
      rxin_q  <= SEL_Z;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      step_q  <= step_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pcinc_q <= pcinc_d;
      rxout_q <= rxout_d;
      rxin_q  <= rxin_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign pcInc = pcinc_q;
  assign rxOut = rxout_q;
  assign rxIn  = rxin_q;

endmodule

// File: tb/tb_rxfer_fsm.sv
// tb/tb_rxfer_fsm.sv - self-checking bench for rxfer_fsm (three parameter sets)
module tb_rxfer_fsm;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       pcinc;
    logic [7:0] out;
    logic [7:0] in;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] instruction;

  logic       busy0, done0, err0, pc0;
  logic [4:0] out0, in0;
  logic       busy1, done1, err1, pc1;
  logic [4:0] out1, in1;
  logic       busy2, done2, err2, pc2;
  logic [3:0] out2, in2;

  rxfer_fsm u0 (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .busy(busy0), .done(done0), .err(err0), .rxOut(out0), .rxIn(in0), .pcInc(pc0)
  );

  rxfer_fsm #(.BUS_CYC(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .busy(busy1), .done(done1), .err(err1), .rxOut(out1), .rxIn(in1), .pcInc(pc1)
  );

  rxfer_fsm #(.NREG(8), .BUS_CYC(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .busy(busy2), .done(done2), .err(err2), .rxOut(out2), .rxIn(in2), .pcInc(pc2)
  );

  exp_t act_v [3];
  assign act_v[0] = {busy0, done0, err0, pc0, 8'(out0), 8'(in0)};
  assign act_v[1] = {busy1, done1, err1, pc1, 8'(out1), 8'(in1)};
  assign act_v[2] = {busy2, done2, err2, pc2, 8'(out2), 8'(in2)};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 0;
  int cyc        = 0;

  // ---------------- behavioural model ----------------
  // On an accepted start the whole per-cycle output sequence is written out
  // from the instruction's transfer list, then replayed one entry per cycle.
  int   p_nreg [3] = '{16, 16, 8};
  int   p_bcyc [3] = '{1, 3, 2};
  exp_t seq  [3][16];
  int   len  [3];
  int   pos  [3];
  exp_t cur  [3];
  logic errh [3];

  function automatic void build(input int i, input logic [15:0] ins);
    int   nreg, b, t, n, s, d;
    int   srcs [3];
    int   dsts [3];
    logic ill;
    exp_t e;
    nreg = p_nreg[i];
    b    = p_bcyc[i];
    t    = nreg + 1;
    s    = int'(ins[3:0]);
    d    = int'(ins[7:4]);
    ill  = (ins[15:12] != 4'h4) || (ins[11:8] > 4'h1) || (s >= nreg) || (d >= nreg);
    n    = 0;
    if (!ill && s != d) begin
      if (ins[11:8] == 4'h0) begin
        srcs[0] = s + 1; dsts[0] = d + 1; n = 1;
      end else begin
        srcs[0] = s + 1; dsts[0] = t;
        srcs[1] = d + 1; dsts[1] = s + 1;
        srcs[2] = t;     dsts[2] = d + 1;
        n = 3;
      end
    end
    len[i] = 0;
    pos[i] = 0;
    e = '0; e.busy = 1'b1;
    seq[i][len[i]] = e; len[i]++;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < b; c++) begin
        e = '0; e.busy = 1'b1; e.err = ill;
        e.out = 8'(srcs[j]);
        e.in  = (c == b - 1) ? 8'(dsts[j]) : 8'd0;
        seq[i][len[i]] = e; len[i]++;
      end
    end
    e = '0; e.busy = 1'b1; e.err = ill; e.pcinc = 1'b1;
    seq[i][len[i]] = e; len[i]++;
    e = '0; e.busy = 1'b1; e.err = ill; e.done = 1'b1;
    seq[i][len[i]] = e; len[i]++;
    errh[i] = ill;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cur[i]  = '0;
        len[i]  = 0;
        pos[i]  = 0;
        errh[i] = 1'b0;
      end else begin
        if (!cur[i].busy && start) build(i, instruction);
        if (pos[i] < len[i]) begin
          cur[i] = seq[i][pos[i]];
          pos[i]++;
        end else begin
          cur[i]     = '0;
          cur[i].err = errh[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (act_v[i] !== cur[i]) begin
          miscompares++;
          $display("FAIL cycle%0d inst%0d: got busy=%b done=%b err=%b pcInc=%b rxOut=%0d rxIn=%0d, want busy=%b done=%b err=%b pcInc=%b rxOut=%0d rxIn=%0d",
                   cyc, i, act_v[i].busy, act_v[i].done, act_v[i].err, act_v[i].pcinc,
                   act_v[i].out, act_v[i].in, cur[i].busy, cur[i].done, cur[i].err,
                   cur[i].pcinc, cur[i].out, cur[i].in);
        end
      end
    end
  end

  // ---------------- directed literal checks ----------------
  exp_t cap [3][1:16];

  function automatic void chk(input string nm, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endfunction

  // Issue one instruction and capture 16 cycles (k=1 is DECODE). Optional
  // start pulse and reset pulse raised at the negedge of cycle k.
  task automatic run(input logic [15:0] ins, input int pulse_at, input int rst_at);
    @(posedge clk); #1;
    start = 1'b1;
    instruction = ins;
    @(posedge clk); #1;
    start = 1'b0;
    instruction = 16'hFFFF;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) cap[i][k] = act_v[i];
      if (k == pulse_at)     start = 1'b1;
      if (k == pulse_at + 1) start = 1'b0;
      if (k == rst_at)       rst = 1'b1;
      if (k == rst_at + 1)   rst = 1'b0;
    end
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    start = 1'b0;
    instruction = 16'h0000;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_rxOut", int'(out0), 0);
    chk("reset_err_done_pc", int'({err0, done0, pc0}), 0);

    run(16'h4012, 0, 0);
    chk("mov_rxOut_E2", int'(cap[0][2].out), 3);
    chk("mov_rxIn_E2", int'(cap[0][2].in), 2);
    chk("mov_pcInc_E3", int'(cap[0][3].pcinc), 1);
    chk("mov_done_E4", int'(cap[0][4].done), 1);
    chk("mov_err", int'(cap[0][4].err), 0);
    chk("mov3_rxOut_E2", int'(cap[1][2].out), 3);
    chk("mov3_rxOut_E3", int'(cap[1][3].out), 3);
    chk("mov3_rxOut_E4", int'(cap[1][4].out), 3);
    chk("mov3_rxIn_E2E3", int'({cap[1][2].in, cap[1][3].in}), 0);
    chk("mov3_rxIn_E4", int'(cap[1][4].in), 2);
    chk("mov3_done_E6", int'(cap[1][6].done), 1);

    run(16'h4135, 0, 0);
    chk("swap_s1", int'({cap[0][2].out, cap[0][2].in}), (6 << 8) | 17);
    chk("swap_s2", int'({cap[0][3].out, cap[0][3].in}), (4 << 8) | 6);
    chk("swap_s3", int'({cap[0][4].out, cap[0][4].in}), (17 << 8) | 4);
    chk("swap_done_E6", int'(cap[0][6].done), 1);

    run(16'h5012, 0, 0);
    chk("badopc_err", int'(cap[0][3].err), 1);
    chk("badopc_pcInc_E2", int'(cap[0][2].pcinc), 1);
    chk("badopc_done_E3", int'(cap[0][3].done), 1);
    chk("badopc_no_sel", int'({cap[0][2].out, cap[0][2].in}), 0);

    run(16'h4712, 0, 0);
    chk("badsub_err", int'(cap[0][3].err), 1);
    chk("badsub_done_E3", int'(cap[0][3].done), 1);

    run(16'h4092, 0, 0);
    chk("nreg8_err", int'(cap[2][3].err), 1);
    chk("nreg8_done_E3", int'(cap[2][3].done), 1);
    chk("nreg16_legal_done_E4", int'(cap[0][4].done), 1);

    run(16'h4044, 2, 0);
    chk("self_done_E3", int'(cap[0][3].done), 1);
    chk("self_no_xfer", int'(cap[0][2].out), 0);
    chk("busy_start_ignored", int'(cap[0][5].busy), 0);

    run(16'h4135, 0, 3);
    chk("rst_outputs_zero", int'(cap[0][4]), 0);
    acc = 0;
    for (int k = 4; k <= 16; k++) acc = acc | int'({cap[0][k].done, cap[0][k].pcinc, cap[0][k].busy});
    chk("rst_no_retire", acc, 0);

    // Random phase: random starts, instructions changing every cycle, rare resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      instruction[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h4;
      instruction[11:8]  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : {3'b000, 1'($urandom)};
      instruction[7:0]   = 8'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rxfer_fsm.md
# rxfer_fsm

Parametrised register-transfer control FSM for the microcontroller's execute stage; next generation of the single-MOV controller. It decodes transfer-class instructions (MOV, SWAP) and sequences register-bus source and destination selects, with a configurable bus hold window per transfer. It issues one PC-increment pulse and one done pulse per instruction. It adds a start/busy handshake and an illegal-instruction flag.

## Interface
- INSTR_W, 16: instruction width (≥ 12 + 2·RI_W is not required; fields below fixed at bits [15:0])
- NREG, 16: architectural registers R0..R(NREG-1), 1..2^RI_W
- RI_W, 4: register index field width
- BUS_CYC, 1: cycles each transfer holds the bus, ≥1
- OPC, 4'b0100: transfer-class opcode
- localparam SEL_W = $clog2(NREG+2): select code width (5 at defaults)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin executing `instruction`; sampled only in IDLE
- instruction  in  INSTR_W  [15:12] opcode, [11:8] subop, [7:4] dst, [3:0] src
- busy  out  1  high from cycle after accepted start through DONE
- done  out  1  one-cycle pulse, instruction retired
- err  out  1  set on illegal instruction, held until next accepted start
- rxOut  out  SEL_W  bus source select code
- rxIn  out  SEL_W  bus destination latch-enable code
- pcInc  out  1  one-cycle PC increment pulse

## Operation
- Select codes: 0 = none; k+1 = Rk; NREG+1 = temp register T.
- Subop 0000 MOV: Rdst ← Rsrc, 1 step. src == dst: zero steps, straight to PCINC.
- Subop 0001 SWAP: T ← Rsrc; Rsrc ← Rdst; Rdst ← T; 3 steps. src == dst: zero steps.
- Illegal: opcode ≠ OPC, other subop, or any index ≥ NREG → err=1, no transfer, still PCINC then DONE.
- States: IDLE → (start) DECODE → XFER (if steps>0) or PCINC → DONE → IDLE.
- IDLE: instruction latched on the accepted start edge; later changes are ignored.
- DECODE: 1 cycle, computes step count and err.
- XFER: per step, rxOut = source code for all BUS_CYC cycles. rxIn = dest code only on the last cycle of the window, and 0 otherwise. The window counter counts BUS_CYC-1 down to 0. Step index advances at 0. After the last step → PCINC.
- PCINC: pcInc=1 for 1 cycle. DONE: done=1 for 1 cycle.
- Outside XFER, rxOut=rxIn=0. start outside IDLE is ignored (not queued).

## Timing
- Reset: state IDLE; busy, done, err, pcInc = 0; rxOut = rxIn = 0; counters 0. Reset mid-operation abandons the instruction. No pcInc or done is issued afterwards.
- Accepted start on edge E: DECODE is cycle E+1. XFER spans cycles E+2 .. E+1+S·BUS_CYC, where S = step count. pcInc is at E+2+S·BUS_CYC. done is at E+3+S·BUS_CYC.
- The earliest next start is accepted on the edge after done, i.e. the first IDLE cycle.
- MOV at BUS_CYC=1: done 4 cycles after start. SWAP: 6 cycles. Illegal or zero-step: 3 cycles.
- rst and start asserted in the same cycle: rst wins.

## Structure
- Package rxfer_pkg:
  - state enum
  - opcode/subop constants
  - SEL_NONE
  - function reg_code(idx) = idx+1
  - temp code NREG+1, computed in the module
- One sub-module, rxfer_win_ctr: loadable BUS_CYC down-counter with a last-cycle flag.
- Decode and step table are combinational in rxfer_fsm.

## Test plan
- Reset, then MOV R1←R2 (0x4012), BUS_CYC=1 → cycle E+2: rxOut=3, rxIn=2. pcInc at E+3, done at E+4. err=0.
- SWAP R3,R5 (0x4135) → (rxOut,rxIn) = (6,17), (4,6), (17,4) on consecutive cycles. done at E+6.
- BUS_CYC=3, MOV 0x4012 → rxOut=3 for 3 cycles. rxIn=2 only on the third. done at E+6.
- Illegal 0x5012, then subop 0x4712, then NREG=8 with 0x4092 → err=1. No nonzero select. pcInc then done at E+3.
- MOV R4←R4 (0x4044) → no transfer. done at E+3. A start pulsed while busy is ignored.
- rst during SWAP step 2 → next cycle all outputs 0, state IDLE. No pcInc or done follows.
